// File: rtl/truth_table_sweeper_if.sv
// Handshake/status bundle between the truth-table sweeper and the environment it checks.
// Optional first-error ports are present only when TT_FIRST_ERR_EN is defined.
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  logic            start;
  logic            dut_f;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
`ifdef TT_FIRST_ERR_EN
  logic [N_IN-1:0] first_err_vec;
  logic            first_err_vld;

  modport master (
    input  start, dut_f,
    output vec_out, busy, done, pass, err_cnt, first_err_vec, first_err_vld
  );
  modport slave (
    output start, dut_f,
    input  vec_out, busy, done, pass, err_cnt, first_err_vec, first_err_vld
  );
`else
  modport master (
    input  start, dut_f,
    output vec_out, busy, done, pass, err_cnt
  );
  modport slave (
    output start, dut_f,
    input  vec_out, busy, done, pass, err_cnt
  );
`endif
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/check engine for an N_IN-input, 1-output combinational DUT.
// Optional feature macro: TT_FIRST_ERR_EN (captures the first failing vector).
module truth_table_sweeper #(
  parameter int                       N_IN   = 4,
  parameter int                       SETTLE = 1,
  parameter logic [(1 << N_IN) - 1:0] EXP_TT = '0
) (
  input logic                   clk,
  input logic                   rst_n,
  truth_table_sweeper_if.master tt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N_IN-1:0] LAST_VEC   = '1;
  localparam logic [7:0]      SETTLE_CNT = 8'(SETTLE);
  localparam logic [N_IN:0]   ERR_MAX    = (N_IN + 1)'(1 << N_IN);

  state_t        state;
  logic [7:0]    cnt;
  logic          mismatch;
  logic [N_IN:0] err_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mismatch = 1'b0;
    err_nxt  = tt.err_cnt;
    mismatch = (tt.dut_f != EXP_TT[tt.vec_out]);
    if (mismatch && (tt.err_cnt != ERR_MAX)) err_nxt = tt.err_cnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; every register, including status outputs, returns to a known value.
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      tt.vec_out <= '0;
      tt.busy    <= 1'b0;
      tt.done    <= 1'b0;
      tt.pass    <= 1'b0;
      tt.err_cnt <= '0;
`ifdef TT_FIRST_ERR_EN
      tt.first_err_vec <= '0;
      tt.first_err_vld <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (tt.start) begin
            state      <= RUN;
            cnt        <= SETTLE_CNT;
            tt.vec_out <= '0;
            tt.busy    <= 1'b1;
            tt.done    <= 1'b0;
            tt.pass    <= 1'b0;
            tt.err_cnt <= '0;
`ifdef TT_FIRST_ERR_EN
            tt.first_err_vec <= '0;
            tt.first_err_vld <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            // Sample edge: the current vector has been held SETTLE+1 cycles.
            tt.err_cnt <= err_nxt;
`ifdef TT_FIRST_ERR_EN
            if (mismatch && !tt.first_err_vld) begin
              tt.first_err_vec <= tt.vec_out;
              tt.first_err_vld <= 1'b1;
            end
`endif
            if (tt.vec_out != LAST_VEC) begin
              tt.vec_out <= tt.vec_out + 1'b1;
              cnt        <= SETTLE_CNT;
            end else begin
              state      <= DONE;
              tt.vec_out <= '0;
              tt.busy    <= 1'b0;
              tt.done    <= 1'b1;
              tt.pass    <= (err_nxt == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
